mig_serial_eval: RTL and testbench



---
 rtl/mig_serial_eval.sv | 148 ++++++++++++++
 tb/tb_mig_serial_eval.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_serial_eval.sv
// rtl/mig_serial_eval.sv - sequential majority-inverter-graph evaluator; optional MIG_GATE_COUNT_EN gate-count register
module mig_serial_eval #(
    parameter int NIN    = 7,
    parameter int NGATES = 8,
    parameter int SELW   = $clog2(1 + NIN + NGATES),
    parameter int CFGW   = 3 * SELW + 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIN-1:0]              in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_bit,
    input  logic                        cfg_we,
    input  logic [$clog2(NGATES+2)-1:0] cfg_addr,
    input  logic [CFGW-1:0]             cfg_data,
    output logic                        cfg_ready
);

    localparam int AW    = $clog2(NGATES + 2);
    localparam int CNTW  = $clog2(NGATES + 1);
    localparam int NODES = 1 << SELW;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t            state;
    logic [CFGW-1:0]   gcfg [NGATES];
    logic [SELW-1:0]   out_sel;
    logic              out_inv;
    logic [NIN-1:0]    xin;
    logic [NGATES-1:0] gval;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   last;

    logic [CFGW-1:0]   cur_cfg;
    logic [NODES-1:0]  nodes_cur;
    logic [NODES-1:0]  nodes_nx;
    logic [NGATES-1:0] gval_nx;
    logic              ga, gb, gc, gnew, res;

    // Node space: 0 is constant 0, then primary inputs, then gates; unused selects stay 0.
    function automatic logic [NODES-1:0] pack_nodes(input logic [NIN-1:0] x, input logic [NGATES-1:0] g);
        logic [NODES-1:0] n;
        n = '0;
        n[NIN:1] = x;
        n[NIN+NGATES:NIN+1] = g;
        return n;
    endfunction

`ifdef MIG_GATE_COUNT_EN
    logic [CNTW-1:0] gcount;
    logic [CNTW-1:0] cnt_raw;
    assign cnt_raw = cfg_data[CNTW-1:0];
    assign last    = gcount - CNTW'(1);
`else
    assign last = CNTW'(NGATES - 1);
`endif

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);

    // Evaluate gate[cnt]; result also folded into the output select so the last gate is visible the same edge.
    always_comb begin
        cur_cfg = '0;
        gval_nx = gval;
        for (int k = 0; k < NGATES; k++) begin
            if (cnt == CNTW'(k)) cur_cfg = gcfg[k];
        end
        nodes_cur = pack_nodes(xin, gval);
        ga   = nodes_cur[cur_cfg[SELW-1:0]]        ^ cur_cfg[3*SELW];
        gb   = nodes_cur[cur_cfg[2*SELW-1:SELW]]   ^ cur_cfg[3*SELW+1];
        gc   = nodes_cur[cur_cfg[3*SELW-1:2*SELW]] ^ cur_cfg[3*SELW+2];
        gnew = (ga & gb) | (ga & gc) | (gb & gc);
        for (int k = 0; k < NGATES; k++) begin
            if (cnt == CNTW'(k)) gval_nx[k] = gnew;
        end
        nodes_nx = pack_nodes(xin, gval_nx);
        res      = nodes_nx[out_sel] ^ out_inv;
    end

    // Control FSM plus config store; config only writable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int k = 0; k < NGATES; k++) gcfg[k] <= '0;
            out_sel   <= '0;
            out_inv   <= 1'b0;
            xin       <= '0;
            gval      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
`ifdef MIG_GATE_COUNT_EN
            gcount    <= CNTW'(NGATES);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        for (int k = 0; k < NGATES; k++) begin
                            if (cfg_addr == AW'(k)) gcfg[k] <= cfg_data;
                        end
                        if (cfg_addr == AW'(NGATES)) begin
                            out_sel <= cfg_data[SELW-1:0];
                            out_inv <= cfg_data[3*SELW];
                        end
`ifdef MIG_GATE_COUNT_EN
                        if (cfg_addr == AW'(NGATES + 1)) begin
                            if (cnt_raw == '0)
                                gcount <= CNTW'(1);
                            else if (cnt_raw > CNTW'(NGATES))
                                gcount <= CNTW'(NGATES);
                            else
                                gcount <= cnt_raw;
                        end
`endif
                    end
                    if (in_valid) begin
                        xin   <= in_data;
                        gval  <= '0;
                        cnt   <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    gval <= gval_nx;
                    cnt  <= cnt + CNTW'(1);
                    if (cnt == last) begin
                        out_valid <= 1'b1;
                        out_bit   <= res;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_bit   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_serial_eval.sv
// tb/tb_mig_serial_eval.sv - self-checking bench for mig_serial_eval
module tb_mig_serial_eval;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_bit;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [14:0] cfg_data = '0;
    logic        cfg_ready;

    int tests = 0;
    int fails = 0;

    logic [14:0] gate_m [8];
    logic [14:0] out_m;
    int          cnt_m;

    mig_serial_eval dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] w(input int sa, input int sb, input int sc,
                                      input bit ia, input bit ib, input bit ic);
        return {ic, ib, ia, 4'(sc), 4'(sb), 4'(sa)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) gate_m[k] = '0;
        out_m = '0;
        cnt_m = 8;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [14:0] d);
        if (a < 4'd8) gate_m[a[2:0]] = d;
        else if (a == 4'd8) out_m = d;
`ifdef MIG_GATE_COUNT_EN
        else if (a == 4'd9) begin
            cnt_m = int'(d[3:0]);
            if (cnt_m == 0) cnt_m = 1;
            if (cnt_m > 8) cnt_m = 8;
        end
`endif
    endtask

    // Node values as plain integers; gates summed and thresholded for majority.
    function automatic bit model(input logic [6:0] x);
        int v[16];
        int a, b, c;
        logic [14:0] g;
        for (int i = 0; i < 16; i++) v[i] = 0;
        for (int i = 0; i < 7; i++) v[i+1] = int'(x[i]);
        for (int k = 0; k < cnt_m; k++) begin
            g = gate_m[k];
            a = v[g[3:0]]  ^ int'(g[12]);
            b = v[g[7:4]]  ^ int'(g[13]);
            c = v[g[11:8]] ^ int'(g[14]);
            v[8+k] = (a + b + c >= 2) ? 1 : 0;
        end
        return 1'(v[out_m[3:0]] ^ int'(out_m[12]));
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [14:0] d);
        @(negedge clk);
        check("cfg_ready_idle", 32'(cfg_ready), 1);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(a, d);
    endtask

    // mode 0 plain, 1 config poke during EVAL, 2 config write on accept edge, 3 hold result 5 cycles
    task automatic run_vector(input logic [6:0] x, input int mode, input logic [3:0] pa,
                              input logic [14:0] pd, output bit r);
        int lat;
        bit exp;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = x;
        if (mode == 2) begin
            cfg_we = 1'b1; cfg_addr = pa; cfg_data = pd;
            model_write(pa, pd);
        end
        exp = model(x);
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("in_ready_busy", 32'(in_ready), 0);
            if (mode == 1 && lat == 2) begin
                @(negedge clk);
                check("cfg_ready_eval", 32'(cfg_ready), 0);
                cfg_we = 1'b1; cfg_addr = pa; cfg_data = pd;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            lat++;
        end
        check("latency", 32'(lat), 32'(cnt_m));
        check("out_valid", 32'(out_valid), 1);
        check("out_bit", 32'(out_bit), 32'(exp));
        r = out_bit;
        if (mode == 3) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = ~x;
            repeat (5) begin
                @(posedge clk); #1;
                check("hold_valid", 32'(out_valid), 1);
                check("hold_bit", 32'(out_bit), 32'(exp));
                check("hold_in_ready", 32'(in_ready), 0);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_valid", 32'(out_valid), 0);
        check("consumed_bit", 32'(out_bit), 0);
        check("consumed_in_ready", 32'(in_ready), 1);
    endtask

    task automatic program_net();
        cfg_write(4'd0, w(1, 2, 6, 0, 0, 0));
        cfg_write(4'd1, w(1, 3, 5, 0, 0, 0));
        cfg_write(4'd2, w(2, 4, 9, 0, 0, 0));
        cfg_write(4'd3, w(1, 5, 6, 0, 0, 0));
        cfg_write(4'd4, w(3, 7, 11, 0, 0, 0));
        cfg_write(4'd5, w(8, 10, 12, 0, 0, 0));
        cfg_write(4'd8, w(13, 0, 0, 0, 0, 0));
    endtask

    logic [6:0] vecs [4];
    bit         vexp [4];

    initial begin
        bit r;
        vecs[0] = 7'h7F; vexp[0] = 1'b1;
        vecs[1] = 7'h03; vexp[1] = 1'b0;
        vecs[2] = 7'h1B; vexp[2] = 1'b1;
        vecs[3] = 7'h00; vexp[3] = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_bit", 32'(out_bit), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vector(7'h7F, 0, 4'd0, 15'd0, r);
        check("unconfigured_result", 32'(r), 0);

        program_net();
        for (int i = 0; i < 4; i++) begin
            run_vector(vecs[i], 0, 4'd0, 15'd0, r);
            check("net6_result", 32'(r), 32'(vexp[i]));
        end

        cfg_write(4'd8, w(13, 0, 0, 1, 0, 0));
        run_vector(7'h1B, 3, 4'd0, 15'd0, r);
        check("inverted_hold_result", 32'(r), 0);

        run_vector(7'h7F, 1, 4'd8, w(0, 0, 0, 1, 0, 0), r);
        check("eval_poke_current", 32'(r), 0);
        run_vector(7'h7F, 0, 4'd0, 15'd0, r);
        check("eval_poke_next", 32'(r), 0);

        run_vector(7'h7F, 2, 4'd8, w(13, 0, 0, 0, 0, 0), r);
        check("write_with_accept", 32'(r), 1);

        cfg_write(4'd10, 15'h7FFF);
        cfg_write(4'd15, 15'h7FFF);
`ifndef MIG_GATE_COUNT_EN
        cfg_write(4'd9, 15'd3);
`endif
        run_vector(7'h1B, 0, 4'd0, 15'd0, r);
        check("unused_addr_ignored", 32'(r), 1);

        @(negedge clk);
        in_valid = 1'b1; in_data = 7'h7F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_cfg_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_vector(7'h7F, 0, 4'd0, 15'd0, r);
        check("after_abort_result", 32'(r), 0);

`ifdef MIG_GATE_COUNT_EN
        program_net();
        cfg_write(4'd9, 15'd6);
        for (int i = 0; i < 4; i++) begin
            run_vector(vecs[i], 0, 4'd0, 15'd0, r);
            check("count6_result", 32'(r), 32'(vexp[i]));
        end
        cfg_write(4'd9, 15'd0);
        run_vector(7'h7F, 0, 4'd0, 15'd0, r);
        check("count0_result", 32'(r), 0);
`endif

        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 0) begin
                for (int k = 0; k < 8; k++) cfg_write(4'(k), 15'($urandom));
                cfg_write(4'd8, 15'($urandom));
`ifdef MIG_GATE_COUNT_EN
                cfg_write(4'd9, 15'($urandom));
`endif
                cfg_write(4'($urandom_range(10, 15)), 15'($urandom));
            end
            run_vector(7'($urandom), 0, 4'd0, 15'd0, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
